// File: rtl/sc_buffer_pkg.sv
// Shared definitions for the note/match slot buffer (deserializer and serializer ends).
// Slot record, default sizing and the wrap-safe lateness test live here.
package sc_buffer_pkg;

    localparam int NUM_SLOTS = 37;
    localparam int TIME_W    = 16;
    localparam int FRET_W    = 5;
    localparam logic [TIME_W-1:0] LATE_WINDOW = 16'd8;

    localparam int SLOT_IDX_W = $clog2(NUM_SLOTS);
    localparam int OCC_W      = $clog2(NUM_SLOTS + 1);

    typedef struct packed {
        logic              valid;
        logic [FRET_W-1:0] fret;
        logic [TIME_W-1:0] tgt_time;
    } slot_t;

    // A negative modular difference means the note is still ahead of song time.
    function automatic logic is_late(input logic [TIME_W-1:0] now,
                                     input logic [TIME_W-1:0] tgt);
        logic [TIME_W-1:0] diff;
        diff = now - tgt;
        return ~diff[TIME_W-1] && (diff > LATE_WINDOW);
    endfunction

endpackage

// File: rtl/sc_lowest_set.sv
// Find-first-set: index of the lowest set bit of vec_i plus a found flag.
module sc_lowest_set #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scanning downward lets the lowest set bit be the last one to assign.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        idx_o   = '0;
        found_o = |vec_i;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/sc_buffer_deserializer.sv
// Loads serial notes into the lowest free slot of a parallel buffer, retires slots
// on matcher hits and expires late slots as misses, one per cycle.
module sc_buffer_deserializer
    import sc_buffer_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [TIME_W-1:0]           song_time,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [FRET_W-1:0]           in_fret,
    input  logic [TIME_W-1:0]           in_time,
    input  logic [NUM_SLOTS-1:0]        match_trigger,
    output logic [NUM_SLOTS-1:0]        slot_valid,
    output logic [NUM_SLOTS*FRET_W-1:0] slot_fret,
    output logic [NUM_SLOTS*TIME_W-1:0] slot_time,
    output logic [OCC_W-1:0]            occupancy,
    output logic                        miss_en,
    output logic [FRET_W-1:0]           miss_fret,
    output logic [TIME_W-1:0]           miss_time
);

    slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
    logic  [OCC_W-1:0]     occ_q, occ_d;
    logic                  miss_en_q;
    logic  [FRET_W-1:0]    miss_fret_q, miss_fret_d;
    logic  [TIME_W-1:0]    miss_time_q, miss_time_d;

    logic [NUM_SLOTS-1:0]  valid_vec, free_vec, late_vec, late_cand, match_hit;
    logic [SLOT_IDX_W-1:0] free_idx, miss_idx;
    logic                  free_found, miss_found, wr_en;
    logic [OCC_W-1:0]      n_match;

    always_comb begin
        valid_vec = '0;
        late_vec  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            valid_vec[i] = slots_q[i].valid;
            late_vec[i]  = slots_q[i].valid & is_late(song_time, slots_q[i].tgt_time);
        end
    end

    // A match on a late slot takes priority, so matched slots never report a miss.
    assign free_vec  = ~valid_vec;
    assign match_hit = match_trigger & valid_vec;
    assign late_cand = late_vec & ~match_trigger;

    sc_lowest_set #(.WIDTH(NUM_SLOTS), .IDX_W(SLOT_IDX_W)) u_free_sel (
        .vec_i   (free_vec),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    sc_lowest_set #(.WIDTH(NUM_SLOTS), .IDX_W(SLOT_IDX_W)) u_late_sel (
        .vec_i   (late_cand),
        .idx_o   (miss_idx),
        .found_o (miss_found)
    );

    // Readiness comes from registered state only, so a same-cycle free never opens a slot.
    assign in_ready = free_found;
    assign wr_en    = in_valid & free_found;

    always_comb begin
        slots_d     = slots_q;
        miss_fret_d = miss_fret_q;
        miss_time_d = miss_time_q;
        n_match     = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (match_hit[i]) slots_d[i].valid = 1'b0;
            n_match = n_match + OCC_W'(match_hit[i]);
        end
        if (miss_found) begin
            slots_d[miss_idx].valid = 1'b0;
            miss_fret_d = slots_q[miss_idx].fret;
            miss_time_d = slots_q[miss_idx].tgt_time;
        end
        if (wr_en) begin
            slots_d[free_idx] = '{valid: 1'b1, fret: in_fret, tgt_time: in_time};
        end
        occ_d = occ_q + OCC_W'(wr_en) - n_match - OCC_W'(miss_found);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: slot storage is reset too, because the flattened fret/time buses must read zero.
            slots_q     <= '0;
            occ_q       <= '0;
            miss_en_q   <= 1'b0;
            miss_fret_q <= '0;
            miss_time_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            slots_q     <= slots_d;
            occ_q       <= occ_d;
            miss_en_q   <= miss_found;
            miss_fret_q <= miss_fret_d;
            miss_time_q <= miss_time_d;
        end
    end

    always_comb begin
        slot_valid = '0;
        slot_fret  = '0;
        slot_time  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_valid[i]                 = slots_q[i].valid;
            slot_fret[i*FRET_W +: FRET_W] = slots_q[i].fret;
            slot_time[i*TIME_W +: TIME_W] = slots_q[i].tgt_time;
        end
    end

    assign occupancy = occ_q;
    assign miss_en   = miss_en_q;
    assign miss_fret = miss_fret_q;
    assign miss_time = miss_time_q;

endmodule

// File: tb/tb_sc_buffer_deserializer.sv
// Directed and randomized bench for sc_buffer_deserializer against a slot-array model.
module tb_sc_buffer_deserializer;

    localparam int N  = 37;
    localparam int FW = 5;
    localparam int TW = 16;

    logic              clk;
    logic              reset;
    logic [TW-1:0]     song_time;
    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     in_fret;
    logic [TW-1:0]     in_time;
    logic [N-1:0]      match_trigger;
    logic [N-1:0]      slot_valid;
    logic [N*FW-1:0]   slot_fret;
    logic [N*TW-1:0]   slot_time;
    logic [5:0]        occupancy;
    logic              miss_en;
    logic [FW-1:0]     miss_fret;
    logic [TW-1:0]     miss_time;

    sc_buffer_deserializer dut (
        .clk           (clk),
        .reset         (reset),
        .song_time     (song_time),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_fret       (in_fret),
        .in_time       (in_time),
        .match_trigger (match_trigger),
        .slot_valid    (slot_valid),
        .slot_fret     (slot_fret),
        .slot_time     (slot_time),
        .occupancy     (occupancy),
        .miss_en       (miss_en),
        .miss_fret     (miss_fret),
        .miss_time     (miss_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain array of occupied notes plus the last reported miss.
    bit            mv [N];
    logic [FW-1:0] mf [N];
    logic [TW-1:0] mt [N];
    bit            em;
    logic [FW-1:0] emf;
    logic [TW-1:0] emt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_late(input logic [TW-1:0] now, input logic [TW-1:0] tgt);
        int unsigned ticks_past;
        ticks_past = int'(16'(now - tgt));
        return (ticks_past >= 9) && (ticks_past < 32768);
    endfunction

    function automatic logic [N-1:0] bit_at(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0;
            mf[i] = '0;
            mt[i] = '0;
        end
        em  = 1'b0;
        emf = '0;
        emt = '0;
    endtask

    task automatic compare_all();
        logic [N-1:0] ev;
        int           cnt;
        ev  = '0;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            ev[i] = mv[i];
            if (mv[i]) cnt++;
        end
        check("slot_valid", 64'(slot_valid), 64'(ev));
        check("occupancy", 64'(occupancy), 64'(cnt));
        check("miss_en", 64'(miss_en), 64'(em));
        check("miss_fret", 64'(miss_fret), 64'(emf));
        check("miss_time", 64'(miss_time), 64'(emt));
        for (int i = 0; i < N; i++) begin
            check($sformatf("slot_fret[%0d]", i), 64'(slot_fret[i*FW +: FW]), 64'(mf[i]));
            check($sformatf("slot_time[%0d]", i), 64'(slot_time[i*TW +: TW]), 64'(mt[i]));
        end
    endtask

    // One clock cycle: drive inputs, check readiness, advance the model, compare state.
    task automatic step(input bit rst, input bit vld, input logic [FW-1:0] f,
                        input logic [TW-1:0] t, input logic [N-1:0] m, input logic [TW-1:0] s);
        bit rdy;
        int widx;
        int midx;
        reset         = rst;
        in_valid      = vld;
        in_fret       = f;
        in_time       = t;
        match_trigger = m;
        song_time     = s;
        #1;
        rdy  = 1'b0;
        widx = -1;
        midx = -1;
        for (int i = 0; i < N; i++) begin
            if (!mv[i]) begin
                rdy = 1'b1;
                if (widx < 0) widx = i;
            end
            if (mv[i] && !m[i] && model_late(s, mt[i]) && midx < 0) midx = i;
        end
        check("in_ready", 64'(in_ready), 64'(rdy));
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) if (m[i]) mv[i] = 1'b0;
            em = (midx >= 0);
            if (midx >= 0) begin
                mv[midx] = 1'b0;
                emf = mf[midx];
                emt = mt[midx];
            end
            if (vld && rdy) begin
                mv[widx] = 1'b1;
                mf[widx] = f;
                mt[widx] = t;
            end
        end
        #1;
        compare_all();
    endtask

    task automatic idle(input logic [TW-1:0] s);
        step(1'b0, 1'b0, '0, '0, '0, s);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        logic [TW-1:0] s;
        logic [N-1:0]  m;

        reset = 1'b1;
        in_valid = 1'b0;
        in_fret = '0;
        in_time = '0;
        match_trigger = '0;
        song_time = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("ready_after_reset", 64'(in_ready), 64'(1));

        // Three back-to-back notes land in slots 0, 1, 2.
        reset = 1'b0;
        step(1'b0, 1'b1, 5'b00001, 16'd20, '0, 16'd0);
        step(1'b0, 1'b1, 5'b00010, 16'd25, '0, 16'd0);
        step(1'b0, 1'b1, 5'b00100, 16'd30, '0, 16'd0);
        check("three_notes_occ", 64'(occupancy), 64'(3));
        check("three_notes_valid", 64'(slot_valid[2:0]), 64'(3'b111));

        // Fill the buffer, hold a note against it, then free slot 12.
        for (int i = 3; i < N; i++) step(1'b0, 1'b1, FW'($urandom), 16'd1000, '0, 16'd0);
        check("full_not_ready", 64'(in_ready), 64'(0));
        step(1'b0, 1'b1, 5'h07, 16'd1000, '0, 16'd0);
        step(1'b0, 1'b1, 5'h07, 16'd1000, bit_at(12), 16'd0);
        check("slot12_freed", 64'(slot_valid[12]), 64'(0));
        step(1'b0, 1'b1, 5'h1F, 16'd1234, '0, 16'd0);
        check("slot12_refill", 64'(slot_fret[12*FW +: FW]), 64'(5'h1F));

        // Single expiry: slot 0 at t=7 expires when song_time reaches 16.
        do_reset();
        step(1'b0, 1'b1, 5'h03, 16'd7, '0, 16'd0);
        for (int t = 7; t <= 16; t++) begin
            idle(16'(t));
            check($sformatf("miss_pulse_t%0d", t), 64'(miss_en), 64'(t == 16));
        end
        check("miss_slot0_time", 64'(miss_time), 64'(7));
        idle(16'd16);
        check("miss_single", 64'(miss_en), 64'(0));

        // Slots 3, 4, 5 late together; slot 4 matched; slot 20 empty match ignored.
        do_reset();
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, FW'(i + 1), (i >= 3) ? 16'd100 : 16'd1000, '0, 16'd0);
        for (int t = 100; t <= 108; t++) idle(16'(t));
        m = bit_at(4) | bit_at(20);
        step(1'b0, 1'b0, '0, '0, m, 16'd109);
        check("miss_slot3_first", 64'(miss_fret), 64'(5'd4));
        idle(16'd109);
        check("miss_slot5_next", 64'(miss_fret), 64'(5'd6));
        check("miss_slot5_en", 64'(miss_en), 64'(1));
        idle(16'd109);
        check("no_miss_slot4", 64'(miss_en), 64'(0));

        // Wrap-around: a note just past zero is future while song time is near the top.
        do_reset();
        step(1'b0, 1'b1, 5'h09, 16'h0002, '0, 16'hFFFA);
        s = 16'hFFFA;
        for (int k = 0; k < 17; k++) begin
            s = s + 16'd1;
            idle(s);
            check($sformatf("wrap_miss_%h", s), 64'(miss_en), 64'(s == 16'h000B));
        end

        // Randomized traffic with occasional reset and sparse matches.
        do_reset();
        s = 16'd50;
        for (int k = 0; k < 500; k++) begin
            m = '0;
            if ($urandom_range(0, 3) == 0) m = m | bit_at($urandom_range(0, N - 1));
            if ($urandom_range(0, 7) == 0) m = m | bit_at($urandom_range(0, N - 1));
            s = s + 16'($urandom_range(0, 2));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, FW'($urandom),
                 s + 16'($urandom_range(0, 40)) - 16'd8, m, s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_buffer_deserializer.md
Name: sc_buffer_deserializer

Overview:
- Parallel-loading end of the note/match slot buffer.
- Accepts a serial stream of upcoming notes (fret pattern + target time) from the song reader and deposits each into the lowest free slot of a NUM_SLOTS-entry parallel buffer.
- Exposes the buffer flattened to the matcher and retires slots on match_trigger from the matcher.
- Slots whose time window has passed are retired as misses, reported one per cycle.

Parameters:
- NUM_SLOTS, 37, number of parallel note slots
- TIME_W, 16, width of song_time and note times
- FRET_W, 5, fret pattern width per note
- LATE_WINDOW, 16'd8, song_time ticks after note time before the slot expires as a miss

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- song_time  in  TIME_W  current song time, monotonic, modular wrap allowed
- in_valid  in  1  serial note present
- in_ready  out  1  buffer can accept a note this cycle
- in_fret  in  FRET_W  fret pattern of the incoming note
- in_time  in  TIME_W  target time of the incoming note
- match_trigger  in  NUM_SLOTS  one-hot-or-more retire-on-hit request per slot
- slot_valid  out  NUM_SLOTS  slot occupied
- slot_fret  out  NUM_SLOTS*FRET_W  flattened; slot i at [i*FRET_W +: FRET_W]
- slot_time  out  NUM_SLOTS*TIME_W  flattened; slot i at [i*TIME_W +: TIME_W]
- occupancy  out  6  count of valid slots (clog2(NUM_SLOTS+1))
- miss_en  out  1  single-cycle pulse, one expired note retired
- miss_fret  out  FRET_W  fret pattern of the missed note
- miss_time  out  TIME_W  target time of the missed note

Behaviour:
- Reset (synchronous, active-high): slot_valid=0, slot_fret=0, slot_time=0, occupancy=0, miss_en=0, miss_fret=0, miss_time=0. Reset mid-operation discards all slots next edge; in_ready reads 1 the cycle after reset deasserts.
- in_ready is combinational: |(~slot_valid). It does not depend on in_valid.
- Write: in_valid & in_ready at edge n → lowest-index free slot (per registered slot_valid) gets fret/time, valid=1, visible at n+1. One write per cycle.
- Match retire: match_trigger[i] & slot_valid[i] at edge n → slot_valid[i]=0 at n+1. Trigger on an invalid slot is ignored. Multiple triggers in one cycle retire all targeted slots.
- Expiry: diff_i = song_time - slot_time_i, computed mod 2^TIME_W.
  - Slot is late when slot_valid[i] & ~diff_i[TIME_W-1] & (diff_i > LATE_WINDOW).
  - Notes up to 2^(TIME_W-1) ticks in the future are never late (wrap-safe).
- Miss reporting: the lowest-index late slot not matched this cycle is retired. miss_en=1 with its fret/time registered (visible n+1). Other late slots retire on following cycles, one per cycle. When no miss occurs: miss_en=0 and miss_fret/miss_time hold their last values.
- Simultaneous events:
  - Match and expiry on the same slot in the same cycle: match wins, no miss.
  - A slot freed this cycle (match or miss) is not writable until the next cycle. The write picks from the pre-update free vector, so no collision is possible.
  - Full buffer with a free happening this cycle: in_ready stays 0 this cycle.
- occupancy updates registered: +1 per write, −1 per retire (match count + miss); consistent with popcount(slot_valid) every cycle.
- No combinational path from match_trigger to any output.

Decomposition:
- Shared package sc_buffer_pkg: NUM_SLOTS, TIME_W, FRET_W, LATE_WINDOW defaults, slot-index width, slot record typedef {valid, fret, time}. The same package is used by sc_buffer_serializer.
- One sub-module: sc_lowest_set (parameterised find-first-set, returns index + found flag). It is instantiated twice: for the free-slot select and for the late-slot select.

Test Plan:
- Reset, then 3 notes (fret 5'b00001/t=20, 5'b00010/t=25, 5'b00100/t=30) back-to-back → slots 0,1,2 valid one cycle after each accept; occupancy=3; in_ready=1.
- Fill all 37 slots → in_ready=0 on full. Hold in_valid → no write. Pulse match_trigger[12] → slot 12 cleared next cycle, in_ready=1, next note lands in slot 12.
- Slot 0 time=7, song_time steps 7→16 → miss_en pulses once when song_time=16 (diff 9>8), with miss_fret/miss_time of slot 0; slot_valid[0]=0.
- Slots 3 and 5 become late on the same cycle → two miss_en pulses on consecutive cycles, slot 3 first.
- match_trigger[4] on the cycle slot 4 becomes late → slot 4 cleared, no miss_en. match_trigger[20] on an empty slot → no state change.
- song_time=16'hFFFA, note time=16'h0002 → not late; song_time wraps to 16'h000B → miss (diff 9).
